memory_cell_arbiter: RTL and testbench
======================================

# memory_cell_arbiter

Port controller and arbiter for the dual-port `memory_cell` activation store. It sequences forward-pass activation writes into consecutive addresses, shares RAM port A between the write stream and read client A, and serves read client B on port B. It also flags the buffer full, resolves same-cycle port-B read-after-write hazards, and aligns read-valid strobes with the RAM's one-cycle registered outputs.

## Interface
- `ADDR`, 12, RAM address width.
- `WIDTH`, 32, data width.
- `NUM`, 2809, entries per timestep.
- `TIMESTEP`, 1, timesteps stored; DEPTH = NUM*TIMESTEP, must be ≤ 2^ADDR.

Ports:
- `clk`  in  1  clock. One clock domain; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous: rewind write pointer, leave FULL.
- `wr_valid`  in  1  write client has data.
- `wr_ready`  out  1  write accepted this cycle.
- `wr_data`  in  WIDTH  activation to store.
- `wr_done`  out  1  one-cycle pulse after the write to address DEPTH-1.
- `ra_valid`  in  1  read request, client A.
- `ra_ready`  out  1  client A read accepted.
- `ra_addr`  in  ADDR  client A address.
- `ra_rvalid`  out  1  client A data valid.
- `ra_rdata`  out  WIDTH  client A data, `mem_o_a` passthrough.
- `rb_valid`  in  1  read request, client B.
- `rb_ready`  out  1  client B read accepted.
- `rb_addr`  in  ADDR  client B address.
- `rb_rvalid`  out  1  client B data valid.
- `rb_rdata`  out  WIDTH  client B data, `mem_o_b` passthrough.
- `mem_wr_a`, `mem_addr_a`, `mem_i_a`  out  1/ADDR/WIDTH  drive RAM port A.
- `mem_addr_b`  out  ADDR  drives RAM port B.
- `mem_o_a`, `mem_o_b`  in  WIDTH  RAM registered outputs.

## Operation

**State machine**

- FILL: writes permitted.
- FULL: `wr_ready`=0.
- FILL→FULL on the accepted write at `wptr`=DEPTH-1; `wptr` wraps to 0.
- Any state→FILL on `clr`; `clr` also sets `wptr`=0.
- `clr` has priority: `wr_ready`=0 in a `clr` cycle.

**Port A arbitration**

- Candidates: write (`wr_valid` and state FILL and not `clr`) and client A read (`ra_valid`).
- Single candidate: granted.
- Both: round-robin on 1-bit `last`; grant the requester not granted last. `last` updates only on contended cycles. Reset value: write wins first contention.
- Write grant: `mem_wr_a`=1, `mem_addr_a`=`wptr`, `mem_i_a`=`wr_data`, `wptr`++.
- Read grant: `mem_wr_a`=0, `mem_addr_a`=`ra_addr`.
- No grant: `mem_wr_a`=0; `mem_addr_a` holds `ra_addr`; no rvalid.
- A write cycle never produces `ra_rvalid` (RAM returns stale data on write).

**Port B**

- `mem_addr_b`=`rb_addr`.
- `rb_ready`=`rb_valid` and not (`mem_wr_a` and `rb_addr`==`wptr`).
- Hazard cycle stalls B one cycle; the next cycle returns new data.

**General rules**

- Grants and readies are combinational from current requests and state.
- Handshake completes on valid&ready at the rising edge.
- Out-of-range addresses (≥DEPTH) are passed through unchecked.

## Timing

**Reset values** (while `rst`=0, asynchronously):
- State FILL, `wptr`=0, `last`=read (write wins next contention).
- `ra_rvalid`=0, `rb_rvalid`=0, `wr_done`=0.

**Latencies**
- Read latency: handshake in cycle N → `x_rvalid`=1 in cycle N+1 with `x_rdata` valid. Fully pipelined: one read per port per cycle.
- Write: stored at the handshake edge; readable by port A the next cycle, by port B the next cycle (hazard stall covers same cycle).
- `wr_done` and FULL: asserted the cycle after the last write.

**Boundary conditions**
- `clr` during a pending rvalid: rvalid still delivered.
- Reset mid-operation: pending rvalids dropped and the write stream restarts at 0.
- Simultaneous write at DEPTH-1 and `clr`: `clr` wins, no write, `wptr`=0.

## Test plan
Bench parameters: NUM=4, TIMESTEP=2 (DEPTH=8), `memory_cell` instance attached.

1. Reset, then stream `wr_data`=0x10..0x17 with `wr_valid` held → `mem_addr_a` 0..7 in order. `wr_done` pulses one cycle after the 8th write. `wr_ready`=0 thereafter; a 9th `wr_valid` is not accepted.
2. Write and `ra_valid` (addr 2) held every cycle from reset → grants alternate W,R,W,R…, write first. Each read yields `ra_rvalid` next cycle with `ra_rdata`=contents of addr 2. No `ra_rvalid` in write cycles.
3. `rb_addr`=3 with `rb_valid` in the cycle `wptr`=3 is written with 0xAB → `rb_ready`=0 that cycle. Next cycle `rb_ready`=1, then `rb_rdata`=0xAB with `rb_rvalid`.
4. FULL state, assert `clr` with `wr_valid`=1 → `wr_ready`=0 that cycle. Next cycle `wr_ready`=1, write lands at addr 0.
5. Port A read issued at cycle N, `rst` dropped at N+0.5 → `ra_rvalid` stays 0. After release, `wptr`=0, state FILL.
6. Back-to-back client B reads at addrs 0..7 after fill → one `rb_rvalid` per cycle with data 0x10..0x17, one cycle latency.

Source files
------------

// File: rtl/memory_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_cell_arbiter
// Description : Port controller and arbiter for the dual-port memory_cell
//               activation store.
//               - Sequences forward-pass activation writes into consecutive
//                 addresses 0..DEPTH-1. The buffer then reports FULL.
//               - Shares RAM port A between the write stream and read
//                 client A. Contention is resolved round-robin.
//               - Serves read client B on RAM port B. A port-B read of the
//                 address being written in the same cycle is stalled.
//               - Aligns the read-valid strobes with the RAM's one-cycle
//                 registered outputs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      clock, all state on rising edge
//   rst          in   1      asynchronous reset, active low
//   i_clr        in   1      rewind write pointer, leave FULL
//   i_wr_valid   in   1      write client has data
//   o_wr_ready   out  1      write accepted this cycle
//   i_wr_data    in   WIDTH  activation to store
//   o_wr_done    out  1      pulse one cycle after the write to DEPTH-1
//   i_ra_valid   in   1      client A read request
//   o_ra_ready   out  1      client A read accepted
//   i_ra_addr    in   ADDR   client A address
//   o_ra_rvalid  out  1      client A data valid
//   o_ra_rdata   out  WIDTH  client A data (RAM port A output)
//   i_rb_valid   in   1      client B read request
//   o_rb_ready   out  1      client B read accepted
//   i_rb_addr    in   ADDR   client B address
//   o_rb_rvalid  out  1      client B data valid
//   o_rb_rdata   out  WIDTH  client B data (RAM port B output)
//   o_mem_wr_a   out  1      RAM port A write enable
//   o_mem_addr_a out  ADDR   RAM port A address
//   o_mem_i_a    out  WIDTH  RAM port A write data
//   o_mem_addr_b out  ADDR   RAM port B address
//   i_mem_o_a    in   WIDTH  RAM port A registered read data
//   i_mem_o_b    in   WIDTH  RAM port B registered read data
// ============================================================================
module memory_cell_arbiter #(
   parameter int ADDR     = 12,
   parameter int WIDTH    = 32,
   parameter int NUM      = 2809,
   parameter int TIMESTEP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_wr_valid,
   output logic             o_wr_ready,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic             o_wr_done,
   input  logic             i_ra_valid,
   output logic             o_ra_ready,
   input  logic [ADDR-1:0]  i_ra_addr,
   output logic             o_ra_rvalid,
   output logic [WIDTH-1:0] o_ra_rdata,
   input  logic             i_rb_valid,
   output logic             o_rb_ready,
   input  logic [ADDR-1:0]  i_rb_addr,
   output logic             o_rb_rvalid,
   output logic [WIDTH-1:0] o_rb_rdata,
   output logic             o_mem_wr_a,
   output logic [ADDR-1:0]  o_mem_addr_a,
   output logic [WIDTH-1:0] o_mem_i_a,
   output logic [ADDR-1:0]  o_mem_addr_b,
   input  logic [WIDTH-1:0] i_mem_o_a,
   input  logic [WIDTH-1:0] i_mem_o_b
);

   localparam int              c_DEPTH     = NUM * TIMESTEP;
   localparam logic [ADDR-1:0] c_LAST_ADDR = ADDR'(c_DEPTH - 1);

   localparam logic [0:0] c_S_FILL = 1'b0;
   localparam logic [0:0] c_S_FULL = 1'b1;

   // Which requester won the most recent contended cycle on port A.
   localparam logic c_LAST_WR = 1'b0;
   localparam logic c_LAST_RD = 1'b1;

   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic [ADDR-1:0] r_wptr;
   logic [ADDR-1:0] w_wptr_nxt;
   logic            r_last;
   logic            w_last_nxt;
   logic            r_ra_rvalid;
   logic            r_rb_rvalid;
   logic            r_wr_done;

   logic            w_wr_req;
   logic            w_contend;
   logic            w_wr_gnt;
   logic            w_rd_gnt;
   logic            w_wr_at_last;
   logic            w_rb_hazard;
   logic            w_rb_fire;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= c_S_FILL;
         r_wptr      <= '0;
         r_last      <= c_LAST_RD;   // the write wins the first contention
         r_ra_rvalid <= 1'b0;
         r_rb_rvalid <= 1'b0;
         r_wr_done   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wptr      <= w_wptr_nxt;
         r_last      <= w_last_nxt;
         // The RAM registers its outputs, so each strobe lags its grant by
         // exactly one cycle. A port-A write grant never raises ra_rvalid.
         r_ra_rvalid <= w_rd_gnt;
         r_rb_rvalid <= w_rb_fire;
         r_wr_done   <= w_wr_gnt && w_wr_at_last;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_wptr_nxt  = r_wptr;
      w_last_nxt  = r_last;

      if (i_clr) begin
         // A clear overrides any write in the same cycle. No write is
         // granted during a clear, so the pointer never advances here.
         w_state_nxt = c_S_FILL;
         w_wptr_nxt  = '0;
      end else if (w_wr_gnt) begin
         if (w_wr_at_last) begin
            w_state_nxt = c_S_FULL;
            w_wptr_nxt  = '0;
         end else begin
            w_wptr_nxt  = r_wptr + ADDR'(1);
         end
      end

      // The fairness bit only moves when both requesters compete.
      if (w_contend) begin
         w_last_nxt = w_wr_gnt ? c_LAST_WR : c_LAST_RD;
      end
   end

   // ------------------------------------------------------------------------
   // Output logic: port-A arbitration and port-B hazard check
   // ------------------------------------------------------------------------
   always_comb begin
      w_wr_req     = i_wr_valid && (r_state == c_S_FILL) && !i_clr;
      w_contend    = w_wr_req && i_ra_valid;
      w_wr_gnt     = w_wr_req && (!i_ra_valid || (r_last == c_LAST_RD));
      w_rd_gnt     = i_ra_valid && !w_wr_gnt;
      w_wr_at_last = (r_wptr == c_LAST_ADDR);
      // The RAM returns the old word when port B reads the address that
      // port A writes on the same edge. Stall B for one cycle instead.
      w_rb_hazard  = w_wr_gnt && (i_rb_addr == r_wptr);
      w_rb_fire    = i_rb_valid && !w_rb_hazard;
   end

   assign o_wr_ready   = w_wr_gnt;
   assign o_ra_ready   = w_rd_gnt;
   assign o_rb_ready   = w_rb_fire;
   assign o_wr_done    = r_wr_done;

   // When neither requester is granted, the address bus carries ra_addr.
   assign o_mem_wr_a   = w_wr_gnt;
   assign o_mem_addr_a = w_wr_gnt ? r_wptr : i_ra_addr;
   assign o_mem_i_a    = i_wr_data;
   assign o_mem_addr_b = i_rb_addr;

   assign o_ra_rvalid  = r_ra_rvalid;
   assign o_ra_rdata   = i_mem_o_a;
   assign o_rb_rvalid  = r_rb_rvalid;
   assign o_rb_rdata   = i_mem_o_b;

endmodule
`default_nettype wire

// File: tb/tb_memory_cell_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_cell_arbiter
// Description : Directed self-checking bench for memory_cell_arbiter.
//               A behavioural dual-port RAM with registered outputs is
//               attached. Expected read data is queued from a reference copy
//               of the memory when a read handshake is expected. It is popped
//               when the DUT strobes rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_cell_arbiter;

   localparam int ADDR = 12;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_clr, i_wr_valid, i_ra_valid, i_rb_valid;
   logic [WIDTH-1:0] i_wr_data;
   logic [ADDR-1:0]  i_ra_addr, i_rb_addr;
   logic             o_wr_ready, o_wr_done, o_ra_ready, o_ra_rvalid;
   logic             o_rb_ready, o_rb_rvalid, o_mem_wr_a;
   logic [WIDTH-1:0] o_ra_rdata, o_rb_rdata, o_mem_i_a;
   logic [ADDR-1:0]  o_mem_addr_a, o_mem_addr_b;
   logic [WIDTH-1:0] mem_o_a, mem_o_b;

   memory_cell_arbiter #(.ADDR(ADDR), .WIDTH(WIDTH), .NUM(4), .TIMESTEP(2)) dut (
      .clk(clk), .rst(rst), .i_clr(i_clr),
      .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
      .o_wr_done(o_wr_done),
      .i_ra_valid(i_ra_valid), .o_ra_ready(o_ra_ready), .i_ra_addr(i_ra_addr),
      .o_ra_rvalid(o_ra_rvalid), .o_ra_rdata(o_ra_rdata),
      .i_rb_valid(i_rb_valid), .o_rb_ready(o_rb_ready), .i_rb_addr(i_rb_addr),
      .o_rb_rvalid(o_rb_rvalid), .o_rb_rdata(o_rb_rdata),
      .o_mem_wr_a(o_mem_wr_a), .o_mem_addr_a(o_mem_addr_a), .o_mem_i_a(o_mem_i_a),
      .o_mem_addr_b(o_mem_addr_b), .i_mem_o_a(mem_o_a), .i_mem_o_b(mem_o_b)
   );

   always #5 clk = ~clk;

   // Dual-port RAM: read-before-write, registered outputs.
   logic [WIDTH-1:0] ram [0:7];
   always @(posedge clk) begin
      if (o_mem_wr_a) ram[o_mem_addr_a[2:0]] <= o_mem_i_a;
      mem_o_a <= ram[o_mem_addr_a[2:0]];
      mem_o_b <= ram[o_mem_addr_b[2:0]];
   end

   logic [WIDTH-1:0] ref_mem [0:7];
   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];
   logic [ADDR-1:0]  exp_wptr;
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock cycle. Inputs are driven just after a rising edge. Comb
   // outputs are checked before the next edge, registered ones after it.
   task automatic step(input logic wv, input logic [31:0] wd,
                       input logic av, input logic [11:0] aa,
                       input logic bv, input logic [11:0] ba,
                       input logic cl,
                       input logic exp_wr, input logic exp_ra, input logic exp_rb);
      logic [31:0] d;
      logic done_exp;
      i_wr_valid = wv; i_wr_data = wd; i_ra_valid = av; i_ra_addr = aa;
      i_rb_valid = bv; i_rb_addr = ba; i_clr = cl;
      #2;
      chk("wr_ready", o_wr_ready, exp_wr);
      chk("ra_ready", o_ra_ready, exp_ra);
      chk("rb_ready", o_rb_ready, exp_rb);
      chk("mem_wr_a", o_mem_wr_a, exp_wr);
      chk("mem_addr_a", o_mem_addr_a, exp_wr ? exp_wptr : aa);
      chk("mem_addr_b", o_mem_addr_b, ba);
      if (exp_ra) qa.push_back(ref_mem[aa[2:0]]);
      if (exp_rb) qb.push_back(ref_mem[ba[2:0]]);
      done_exp = 1'b0;
      if (exp_wr) begin
         ref_mem[exp_wptr[2:0]] = wd;
         done_exp = (exp_wptr == 12'd7);
         exp_wptr = done_exp ? 12'd0 : exp_wptr + 12'd1;
      end
      if (cl) exp_wptr = 12'd0;
      @(posedge clk); #1;
      chk("ra_rvalid", o_ra_rvalid, exp_ra);
      if (exp_ra && qa.size() > 0) begin
         d = qa.pop_front();
         chk("ra_rdata", o_ra_rdata, d);
      end
      chk("rb_rvalid", o_rb_rvalid, exp_rb);
      if (exp_rb && qb.size() > 0) begin
         d = qb.pop_front();
         chk("rb_rdata", o_rb_rdata, d);
      end
      chk("wr_done", o_wr_done, done_exp);
   endtask

   task automatic do_reset();
      i_wr_valid = 0; i_ra_valid = 0; i_rb_valid = 0; i_clr = 0;
      i_wr_data = '0; i_ra_addr = '0; i_rb_addr = '0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ra_rvalid", o_ra_rvalid, 1'b0);
      chk("rst_rb_rvalid", o_rb_rvalid, 1'b0);
      chk("rst_wr_done", o_wr_done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_wptr = '0;
   endtask

   initial begin
      logic [31:0] k;
      for (int i = 0; i < 8; i++) begin ram[i] = '0; ref_mem[i] = '0; end
      do_reset();

      // Fill stream: 0x10..0x17 land at addresses 0..7, then FULL.
      for (int i = 0; i < 8; i++) step(1, 32'h10 + i, 0, 0, 0, 0, 0, 1, 0, 0);
      step(1, 32'h18, 0, 0, 0, 0, 0, 0, 0, 0);

      // Back-to-back client B reads of the filled buffer.
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 12'(i), 0, 0, 0, 1);

      // Clear while FULL with a write pending: clear wins, then write at 0.
      step(1, 32'h20, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 32'h20, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 12'd0, 0, 0, 0, 0, 1, 0);

      // Port-B read-after-write hazard at address 3.
      step(1, 32'h21, 0, 0, 0, 0, 0, 1, 0, 0);
      step(1, 32'h22, 0, 0, 0, 0, 0, 1, 0, 0);
      step(1, 32'hAB, 0, 0, 1, 12'd3, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 12'd3, 0, 0, 0, 1);
      step(1, 32'h24, 0, 0, 1, 12'd2, 0, 1, 0, 1);

      // Contention from reset: write first, then alternate.
      do_reset();
      k = 32'h30;
      for (int i = 0; i < 8; i++) begin
         step(1, k, 1, 12'd2, 0, 0, 0, (i % 2) == 0, (i % 2) == 1, 0);
         if ((i % 2) == 0) k = k + 1;
      end

      // Reset asserted mid-cycle while a port-A read is requested.
      i_wr_valid = 0; i_ra_valid = 1; i_ra_addr = 12'd2; i_rb_valid = 0; i_clr = 0;
      #2;
      chk("pre_rst_ra_ready", o_ra_ready, 1'b1);
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_drop_ra_rvalid", o_ra_rvalid, 1'b0);
      i_ra_valid = 0;
      @(posedge clk); #1;
      chk("rst_hold_ra_rvalid", o_ra_rvalid, 1'b0);
      rst = 1'b1;
      exp_wptr = '0;
      step(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 12'd0, 0, 0, 0, 0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
